// File: rtl/pipeline_ctrl_pkg.sv
// Shared MIPS pipeline constants: forwarding selects, opcodes and the
// shadow-entry layouts kept for the EX, MEM and WB stages.
package mips_pipe_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;

    typedef logic [4:0] reg_idx_t;

    typedef struct packed {
        logic     valid;
        reg_idx_t rs;
        reg_idx_t rt;
        reg_idx_t dest;
        logic     reg_write;
        logic     mem_to_reg;
        logic     mem_write;
    } ex_entry_t;

    typedef struct packed {
        logic     valid;
        reg_idx_t dest;
        logic     reg_write;
        logic     mem_to_reg;
        logic     mem_write;
    } mem_entry_t;

    typedef struct packed {
        logic     valid;
        reg_idx_t dest;
        logic     reg_write;
    } wb_entry_t;

    // $0 is hard-wired, so a write to it is never a forwarding source.
    function automatic logic writes_reg(input logic valid, input logic rw, input reg_idx_t dest);
        return valid & rw & (dest != 5'd0);
    endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Handshake bundle between the ID-stage decoder/datapath and the pipeline
// sequencing controller.
interface pipeline_ctrl_if #(parameter int CNT_W = 16);
    logic             id_valid;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rs;
    logic             id_uses_rt;
    logic [4:0]       id_dest;
    logic             id_reg_write;
    logic             id_mem_to_reg;
    logic             id_mem_write;
    logic             ex_flush;
    logic             mem_ready;
    logic             pc_en;
    logic             ifid_en;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             pipe_en;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic [CNT_W-1:0] lu_stall_cnt;
    logic [CNT_W-1:0] mem_wait_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_dest,
               id_reg_write, id_mem_to_reg, id_mem_write, ex_flush, mem_ready,
        input  pc_en, ifid_en, ifid_flush, idex_bubble, pipe_en, fwd_a, fwd_b,
               lu_stall_cnt, mem_wait_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_dest,
               id_reg_write, id_mem_to_reg, id_mem_write, ex_flush, mem_ready,
        output pc_en, ifid_en, ifid_flush, idex_bubble, pipe_en, fwd_a, fwd_b,
               lu_stall_cnt, mem_wait_cnt
    );
endinterface

// File: rtl/pipeline_ctrl_fwd_sel.sv
// One EX operand's forwarding select; the nearer stage (MEM) wins over WB.
module fwd_sel
    import mips_pipe_pkg::*;
(
    input  logic       i_ex_valid,
    input  reg_idx_t   i_src,
    input  logic       i_mem_valid,
    input  logic       i_mem_reg_write,
    input  reg_idx_t   i_mem_dest,
    input  logic       i_wb_valid,
    input  logic       i_wb_reg_write,
    input  reg_idx_t   i_wb_dest,
    output logic [1:0] o_fwd
);
    always_comb begin
        o_fwd = FWD_RF;
        if (i_ex_valid) begin
            if (writes_reg(i_mem_valid, i_mem_reg_write, i_mem_dest) && (i_mem_dest == i_src))
                o_fwd = FWD_MEM;
            else if (writes_reg(i_wb_valid, i_wb_reg_write, i_wb_dest) && (i_wb_dest == i_src))
                o_fwd = FWD_WB;
        end
    end
endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencing controller: shadows EX/MEM/WB control fields and derives
// stalls, flushes, memory-wait freezes, forwarding selects and stall counters.
module pipeline_ctrl
    import mips_pipe_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input logic         clk,
    input logic         rst,
    pipeline_ctrl_if.slave bus
);
    ex_entry_t        r_ex;
    mem_entry_t       r_mem;
    wb_entry_t        r_wb;
    logic [CNT_W-1:0] r_lu_cnt;
    logic [CNT_W-1:0] r_mw_cnt;

    logic      w_mem_wait;
    logic      w_load_use;
    logic      w_flush;
    logic      w_pc_en;
    logic      w_ifid_en;
    logic      w_ifid_flush;
    logic      w_idex_bubble;
    logic      w_pipe_en;
    ex_entry_t w_ex_next;

    assign w_mem_wait = r_mem.valid & (r_mem.mem_to_reg | r_mem.mem_write) & ~bus.mem_ready;
    // Masking with rst keeps outputs at their reset values even if ex_flush is high during reset.
    assign w_flush    = bus.ex_flush & ~rst;
    assign w_load_use = bus.id_valid & r_ex.valid & r_ex.mem_to_reg & (r_ex.dest != 5'd0) &
                        ((bus.id_uses_rs & (bus.id_rs == r_ex.dest)) |
                         (bus.id_uses_rt & (bus.id_rt == r_ex.dest))) & ~rst;

    always_comb begin
        w_pc_en       = 1'b1;
        w_ifid_en     = 1'b1;
        w_ifid_flush  = 1'b0;
        w_idex_bubble = 1'b0;
        w_pipe_en     = 1'b1;
        if (w_mem_wait) begin
            w_pc_en   = 1'b0;
            w_ifid_en = 1'b0;
            w_pipe_en = 1'b0;
        end else if (w_flush) begin
            w_ifid_flush  = 1'b1;
            w_idex_bubble = 1'b1;
        end else if (w_load_use) begin
            w_pc_en       = 1'b0;
            w_ifid_en     = 1'b0;
            w_idex_bubble = 1'b1;
        end
    end

    always_comb begin
        w_ex_next            = '0;
        if (!w_idex_bubble) begin
            w_ex_next.valid      = bus.id_valid;
            w_ex_next.rs         = bus.id_rs;
            w_ex_next.rt         = bus.id_rt;
            w_ex_next.dest       = bus.id_dest;
            w_ex_next.reg_write  = bus.id_reg_write;
            w_ex_next.mem_to_reg = bus.id_mem_to_reg;
            w_ex_next.mem_write  = bus.id_mem_write;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex     <= '0;
            r_mem    <= '0;
            r_wb     <= '0;
            r_lu_cnt <= '0;
            r_mw_cnt <= '0;
        end else begin
            if (w_pipe_en) begin
                r_wb.valid       <= r_mem.valid;
                r_wb.dest        <= r_mem.dest;
                r_wb.reg_write   <= r_mem.reg_write;
                r_mem.valid      <= r_ex.valid;
                r_mem.dest       <= r_ex.dest;
                r_mem.reg_write  <= r_ex.reg_write;
                r_mem.mem_to_reg <= r_ex.mem_to_reg;
                r_mem.mem_write  <= r_ex.mem_write;
                r_ex             <= w_ex_next;
            end
            if (w_load_use && !w_mem_wait && !w_flush && (r_lu_cnt != '1))
                r_lu_cnt <= r_lu_cnt + CNT_W'(1);
            if (w_mem_wait && (r_mw_cnt != '1))
                r_mw_cnt <= r_mw_cnt + CNT_W'(1);
        end
    end

    reg_idx_t   w_src [2];
    logic [1:0] w_fwd [2];

    assign w_src[0] = r_ex.rs;
    assign w_src[1] = r_ex.rt;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            fwd_sel u_fwd_sel (
                .i_ex_valid      (r_ex.valid),
                .i_src           (w_src[gi]),
                .i_mem_valid     (r_mem.valid),
                .i_mem_reg_write (r_mem.reg_write),
                .i_mem_dest      (r_mem.dest),
                .i_wb_valid      (r_wb.valid),
                .i_wb_reg_write  (r_wb.reg_write),
                .i_wb_dest       (r_wb.dest),
                .o_fwd           (w_fwd[gi])
            );
        end
    endgenerate

    assign bus.pc_en        = w_pc_en;
    assign bus.ifid_en      = w_ifid_en;
    assign bus.ifid_flush   = w_ifid_flush;
    assign bus.idex_bubble  = w_idex_bubble;
    assign bus.pipe_en      = w_pipe_en;
    assign bus.fwd_a        = w_fwd[0];
    assign bus.fwd_b        = w_fwd[1];
    assign bus.lu_stall_cnt = r_lu_cnt;
    assign bus.mem_wait_cnt = r_mw_cnt;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl; a narrow counter width makes saturation reachable.
module tb_pipeline_ctrl;
    localparam int CW = 4;

    // Control vector order: {pc_en, ifid_en, ifid_flush, idex_bubble, pipe_en}
    localparam logic [4:0] C_NORM   = 5'b11001;
    localparam logic [4:0] C_STALL  = 5'b00011;
    localparam logic [4:0] C_FLUSH  = 5'b11111;
    localparam logic [4:0] C_FREEZE = 5'b00000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    pipeline_ctrl_if #(.CNT_W(CW)) pif();

    pipeline_ctrl #(.CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (pif)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] ctl();
        return {pif.pc_en, pif.ifid_en, pif.ifid_flush, pif.idex_bubble, pif.pipe_en};
    endfunction

    function automatic logic [3:0] fwd();
        return {pif.fwd_a, pif.fwd_b};
    endfunction

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic urs, input logic urt, input logic [4:0] dest,
                          input logic rw, input logic m2r, input logic mw);
        pif.id_valid      = v;
        pif.id_rs         = rs;
        pif.id_rt         = rt;
        pif.id_uses_rs    = urs;
        pif.id_uses_rt    = urt;
        pif.id_dest       = dest;
        pif.id_reg_write  = rw;
        pif.id_mem_to_reg = m2r;
        pif.id_mem_write  = mw;
    endtask

    task automatic idle_id();
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic step();
        $display("cyc %0d ctl=%b fwd=%b lu=%0d mw=%0d", cyc, ctl(), fwd(),
                 pif.lu_stall_cnt, pif.mem_wait_cnt);
        @(negedge clk);
        cyc++;
        #1;
    endtask

    task automatic drain();
        idle_id();
        pif.ex_flush  = 1'b0;
        pif.mem_ready = 1'b1;
        repeat (3) step();
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (ctl() !== C_NORM) begin errors++; $display("FAIL reset_ctl got=%b exp=%b", ctl(), C_NORM); end
        checks++;
        if (fwd() !== 4'b0000) begin errors++; $display("FAIL reset_fwd got=%b exp=0000", fwd()); end
        checks++;
        if ({pif.lu_stall_cnt, pif.mem_wait_cnt} !== 8'h00) begin
            errors++; $display("FAIL reset_cnt got=%h exp=00", {pif.lu_stall_cnt, pif.mem_wait_cnt});
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic test_load_use();
        set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0);   // lw $2
        #1;
        checks++;
        if (ctl() !== C_NORM) begin errors++; $display("FAIL lu_c0 got=%b exp=%b", ctl(), C_NORM); end
        step();
        set_id(1'b1, 5'd2, 5'd4, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);   // add $3,$2,$4
        #1;
        checks++;
        if (ctl() !== C_STALL) begin errors++; $display("FAIL lu_stall got=%b exp=%b", ctl(), C_STALL); end
        step();
        checks++;
        if (ctl() !== C_NORM) begin errors++; $display("FAIL lu_single got=%b exp=%b", ctl(), C_NORM); end
        step();
        idle_id();
        #1;
        checks++;
        if (fwd() !== 4'b0100) begin errors++; $display("FAIL lu_fwd got=%b exp=0100", fwd()); end
        checks++;
        if (pif.lu_stall_cnt !== 4'd1) begin errors++; $display("FAIL lu_cnt got=%0d exp=1", pif.lu_stall_cnt); end
        drain();
    endtask

    task automatic test_forward();
        set_id(1'b1, 5'd1, 5'd1, 1'b1, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0);   // add $2
        step();
        set_id(1'b1, 5'd2, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);   // sub $5,$2,$2
        #1;
        checks++;
        if (ctl() !== C_NORM) begin errors++; $display("FAIL fw_nostall got=%b exp=%b", ctl(), C_NORM); end
        step();
        idle_id();
        #1;
        checks++;
        if (fwd() !== 4'b1010) begin errors++; $display("FAIL fw_mem got=%b exp=1010", fwd()); end
        drain();
        set_id(1'b1, 5'd1, 5'd1, 1'b1, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0);
        step();
        idle_id();
        step();
        set_id(1'b1, 5'd2, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        step();
        idle_id();
        #1;
        checks++;
        if (fwd() !== 4'b0101) begin errors++; $display("FAIL fw_wb got=%b exp=0101", fwd()); end
        drain();
        set_id(1'b1, 5'd1, 5'd1, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);   // add $0
        step();
        set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        step();
        idle_id();
        #1;
        checks++;
        if (fwd() !== 4'b0000) begin errors++; $display("FAIL fw_r0 got=%b exp=0000", fwd()); end
        drain();
    endtask

    task automatic test_fwd_priority();
        set_id(1'b1, 5'd1, 5'd1, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);   // add $7
        step();
        set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);   // addi $7
        step();
        set_id(1'b1, 5'd7, 5'd1, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);   // add $8,$7,$1
        step();
        idle_id();
        #1;
        checks++;
        if (fwd() !== 4'b1000) begin errors++; $display("FAIL fw_prio got=%b exp=1000", fwd()); end
        drain();
    endtask

    task automatic test_mem_wait();
        set_id(1'b1, 5'd1, 5'd1, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);   // add $9
        step();
        set_id(1'b1, 5'd0, 5'd9, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);   // sw $9
        step();
        set_id(1'b1, 5'd9, 5'd9, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0);  // add $10,$9,$9
        step();
        set_id(1'b1, 5'd1, 5'd1, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0);  // or $11
        pif.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pif.ex_flush = (i == 1);
            #1;
            checks++;
            if (ctl() !== C_FREEZE) begin errors++; $display("FAIL mw_freeze%0d got=%b exp=%b", i, ctl(), C_FREEZE); end
            checks++;
            if (fwd() !== 4'b0101) begin errors++; $display("FAIL mw_fwd%0d got=%b exp=0101", i, fwd()); end
            step();
        end
        pif.ex_flush  = 1'b0;
        pif.mem_ready = 1'b1;
        #1;
        checks++;
        if (ctl() !== C_NORM) begin errors++; $display("FAIL mw_resume got=%b exp=%b", ctl(), C_NORM); end
        checks++;
        if (fwd() !== 4'b0101) begin errors++; $display("FAIL mw_held got=%b exp=0101", fwd()); end
        step();
        idle_id();
        #1;
        checks++;
        if (fwd() !== 4'b0000) begin errors++; $display("FAIL mw_adv got=%b exp=0000", fwd()); end
        checks++;
        if (pif.mem_wait_cnt !== 4'd3) begin errors++; $display("FAIL mw_cnt got=%0d exp=3", pif.mem_wait_cnt); end
        drain();
    endtask

    task automatic test_flush();
        set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0);   // lw $2
        step();
        set_id(1'b1, 5'd2, 5'd4, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
        pif.ex_flush = 1'b1;
        #1;
        checks++;
        if (ctl() !== C_FLUSH) begin errors++; $display("FAIL fl_ctl got=%b exp=%b", ctl(), C_FLUSH); end
        step();
        pif.ex_flush = 1'b0;
        #1;
        checks++;
        if (ctl() !== C_NORM) begin errors++; $display("FAIL fl_after got=%b exp=%b", ctl(), C_NORM); end
        checks++;
        if (pif.lu_stall_cnt !== 4'd1) begin errors++; $display("FAIL fl_cnt got=%0d exp=1", pif.lu_stall_cnt); end
        drain();
    endtask

    task automatic test_reset_freeze();
        set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0);   // lw $6
        step();
        idle_id();
        step();
        pif.mem_ready = 1'b0;
        #1;
        checks++;
        if (ctl() !== C_FREEZE) begin errors++; $display("FAIL rf_freeze got=%b exp=%b", ctl(), C_FREEZE); end
        step();
        rst = 1'b1;
        #1;
        checks++;
        if (ctl() !== C_NORM) begin errors++; $display("FAIL rf_async got=%b exp=%b", ctl(), C_NORM); end
        checks++;
        if ({pif.lu_stall_cnt, pif.mem_wait_cnt} !== 8'h00) begin
            errors++; $display("FAIL rf_cnt got=%h exp=00", {pif.lu_stall_cnt, pif.mem_wait_cnt});
        end
        rst = 1'b0;
        pif.mem_ready = 1'b1;
        step();
    endtask

    task automatic test_saturate();
        set_id(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0);   // lw $2,0($2)
        repeat (40) step();
        checks++;
        if (pif.lu_stall_cnt !== 4'hF) begin errors++; $display("FAIL sat_cnt got=%h exp=F", pif.lu_stall_cnt); end
        step();
        checks++;
        if (ctl() !== C_STALL) begin errors++; $display("FAIL sat_stall got=%b exp=%b", ctl(), C_STALL); end
        step();
        checks++;
        if (pif.lu_stall_cnt !== 4'hF) begin errors++; $display("FAIL sat_hold got=%h exp=F", pif.lu_stall_cnt); end
        step();
        rst = 1'b1;
        #1;
        checks++;
        if (ctl() !== C_NORM) begin errors++; $display("FAIL sat_rst got=%b exp=%b", ctl(), C_NORM); end
        checks++;
        if (pif.lu_stall_cnt !== 4'h0) begin errors++; $display("FAIL sat_rstcnt got=%h exp=0", pif.lu_stall_cnt); end
        rst = 1'b0;
        idle_id();
        step();
    endtask

    initial begin
        idle_id();
        pif.ex_flush  = 1'b0;
        pif.mem_ready = 1'b1;
        test_reset();
        test_load_use();
        test_forward();
        test_fwd_priority();
        test_mem_wait();
        test_flush();
        test_reset_freeze();
        test_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central sequencing controller for the 5-stage MIPS pipeline, sitting beside the main decoder in ID. It keeps shadow copies of the control and register-index fields for the EX, MEM and WB stages, and from them produces:
- load-use stalls and bubbles
- branch flushes
- a global freeze while data memory is not ready
- EX-stage operand forwarding selects
It also counts stall cycles for performance analysis.

Parameters:
CNT_W, 16, width of each saturating stall counter

Ports:
clk  in  1  pipeline clock, rising edge
rst  in  1  asynchronous reset, active-high
id_valid  in  1  ID holds a real instruction
id_rs  in  5  rs field of ID instruction
id_rt  in  5  rt field of ID instruction
id_uses_rs  in  1  ID instruction reads rs
id_uses_rt  in  1  ID instruction reads rt
id_dest  in  5  destination register after regDst mux
id_reg_write  in  1  decoded regWrite
id_mem_to_reg  in  1  decoded memtoReg (load)
id_mem_write  in  1  decoded memWrite (store)
ex_flush  in  1  branch/jump taken, resolved in EX
mem_ready  in  1  data memory completes access this cycle
pc_en  out  1  PC register write enable
ifid_en  out  1  IF/ID register write enable
ifid_flush  out  1  clear IF/ID to NOP
idex_bubble  out  1  load NOP control into ID/EX
pipe_en  out  1  ID/EX, EX/MEM, MEM/WB write enable
fwd_a  out  2  EX operand A select
fwd_b  out  2  EX operand B select
lu_stall_cnt  out  CNT_W  load-use stall cycles
mem_wait_cnt  out  CNT_W  memory-wait freeze cycles

Behaviour:
- Shadow state:
  - EX entry: valid, rs, rt, dest, reg_write, mem_to_reg, mem_write.
  - MEM entry: valid, dest, reg_write, mem_to_reg, mem_write.
  - WB entry: valid, dest, reg_write.
- Reset (async, rst=1): all valid bits and counters go to 0. Outputs then read pc_en=1, ifid_en=1, ifid_flush=0, idex_bubble=0, pipe_en=1, fwd_a=fwd_b=2'b00.
- mem_wait = MEM.valid & (MEM.mem_to_reg | MEM.mem_write) & ~mem_ready.
- load_use = id_valid & EX.valid & EX.mem_to_reg & EX.dest!=0 & ((id_uses_rs & id_rs==EX.dest) | (id_uses_rt & id_rt==EX.dest)).
- Priority is mem_wait > ex_flush > load_use > normal.
  - mem_wait: pc_en=ifid_en=pipe_en=0, ifid_flush=idex_bubble=0. All shadow entries hold. ex_flush is ignored, so its source must hold it until a cycle with pipe_en=1.
  - ex_flush: pc_en=1 (loads target), ifid_flush=1, idex_bubble=1, pipe_en=1. The next EX entry is invalid; the load_use stall is suppressed.
  - load_use: pc_en=ifid_en=0, idex_bubble=1, pipe_en=1. The next EX entry is invalid. This gives exactly one stall cycle per load-use pair.
  - normal: all enables 1. EX takes the ID fields with valid=id_valid.
- On every cycle with pipe_en=1: WB<=MEM and MEM<=EX (fields and valid).
- Outputs are combinational from shadow state plus current inputs. Decisions take zero added latency; state updates at the next rising edge.
- Forwarding, per operand (rs for A, rt for B, from the EX entry; EX.valid must be 1):
  - 2'b10 if MEM.valid & MEM.reg_write & MEM.dest!=0 & MEM.dest==operand.
  - else 2'b01 if WB.valid & WB.reg_write & WB.dest!=0 & WB.dest==operand.
  - else 2'b00.
  - MEM has priority over WB when both match.
  - Register 0 is never forwarded.
  - Forwarding selects stay valid during a freeze.
- Counters saturate at all-ones and never wrap.
  - lu_stall_cnt increments on load_use cycles not masked by mem_wait or ex_flush.
  - mem_wait_cnt increments on mem_wait cycles.
- Reset mid-stall or mid-freeze: all entries are invalidated immediately and outputs return to their reset values asynchronously.

Decomposition:
- Package mips_pipe_pkg holds:
  - FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - Opcode constants shared with the decoder (R-type 000000, lw 100011, sw 101011, addi 001000, andi 001100).
- Sub-module fwd_sel computes one operand's 2-bit select from the operand index and the MEM/WB fields. It is instantiated twice, for A and B.

Test Plan:
1. lw $2 then add $3,$2,$4 back-to-back -> exactly one cycle with pc_en=0, ifid_en=0, idex_bubble=1. Next cycle add is in EX with fwd_a=2'b01. lu_stall_cnt=1.
2. add $2 then sub $5,$2,$2 -> no stall, fwd_a=fwd_b=2'b10. Two instructions apart -> 2'b01. Destination $0 -> 2'b00.
3. MEM and WB both write $7, EX reads $7 -> fwd_a=2'b10 (MEM priority).
4. Store in MEM with mem_ready=0 for 3 cycles -> pipe_en=pc_en=0 for 3 cycles, shadow state and fwd selects unchanged, mem_wait_cnt=3, then normal flow resumes.
5. ex_flush=1 while the ID instruction would trigger load_use -> ifid_flush=1, idex_bubble=1, pc_en=1, lu_stall_cnt unchanged.
6. Assert rst during a freeze; separately, force lu_stall_cnt to all-ones and create another load_use -> on reset, outputs return to reset values without a clock edge. The saturated counter stays at all-ones.
